interrupt_ctrl: RTL
===================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 phi1  input  1  Single system clock; all state updates on posedge phi1.
REQ-002 rstAll  input  1  Reset: synchronous, active-high, sampled on posedge phi1.
REQ-003 NMI_n  input  1  External non-maskable interrupt pin, active-low, asynchronous to phi1.
REQ-004 IRQ_n  input  1  External maskable interrupt pin, active-low, level-sensitive, asynchronous.
REQ-005 RES_n  input  1  External reset pin, active-low, asynchronous.
REQ-006 statusReg  input  8  Processor status; bit 2 is the I (interrupt-disable) flag.
REQ-007 nmiHandled  input  1  One-cycle acknowledge from the control FSM: NMI sequence completed.
REQ-008 irqHandled  input  1  One-cycle acknowledge: IRQ sequence completed.
REQ-009 rstHandled  input  1  One-cycle acknowledge: reset sequence completed.
REQ-010 nmi  output  1  NMI request to the control FSM, active-high, held until acknowledged.
REQ-011 irq  output  1  IRQ request, active-high.
REQ-012 rst  output  1  Reset request, active-high, held until acknowledged.
REQ-013 nmiCount  output  4  Saturating count of NMI edges that arrived while an NMI was already pending.

Function
REQ-014 Each pin passes through a 2-flop synchronizer; all logic below uses synchronized values (sNMI, sIRQ, sRES).
REQ-015 NMI is edge-triggered: a 1->0 transition of sNMI sets nmiPend on the next edge; latency from pin fall to nmi=1 is 3 phi1 cycles.
REQ-016 nmi deasserts the cycle after nmiHandled=1; if a new sNMI falling edge coincides with nmiHandled, nmiPend stays 1 (set wins).
REQ-017 A falling edge while nmiPend=1 and nmiHandled=0 increments nmiCount, saturating at 15; nmiCount holds otherwise.
REQ-018 irq = ~sIRQ & ~statusReg[2], registered; latency from pin fall to irq=1 is 3 cycles with I=0.
REQ-019 IRQ is not latched: releasing IRQ_n before service drops irq 3 cycles later; irqHandled has no effect on irq.
REQ-020 Reset FSM states RS_IDLE, RS_LOW, RS_PEND; encoding 2 bits.
REQ-021 RS_IDLE -> RS_LOW when sRES=0; the low-cycle counter (3 bits) is cleared on entry.
REQ-022 RS_LOW: counter increments each cycle sRES=0, saturating at 7; sRES=1 with counter>=2 -> RS_PEND; sRES=1 with counter<2 -> RS_IDLE (pulse rejected).
REQ-023 RS_PEND: rst=1; rstHandled=1 -> RS_IDLE; sRES=0 -> RS_LOW (reset re-armed, rst drops).
REQ-024 rst=1 only in RS_PEND; nmi and irq are forced 0 while the FSM is in RS_LOW or RS_PEND.
REQ-025 Acknowledges for sources that are not pending are ignored.

Reset
REQ-026 rstAll=1 on posedge phi1: synchronizers load 1 (pins inactive), nmiPend=0, nmiCount=0, irq=0, reset FSM=RS_IDLE, rst=0.
REQ-027 rstAll overrides all acknowledges and pin activity in the same cycle; after release, a pin still held low is detected as level (IRQ, RES) but produces no NMI edge.

Configuration
REQ-028 INTC_GLITCH_FILTER_EN defined: each synchronized pin feeds a 2-cycle stability filter; a filtered value changes only after 2 consecutive equal samples, adding 2 cycles to every latency in REQ-015/018.
REQ-029 INTC_GLITCH_FILTER_EN undefined: no filter; latencies exactly as in REQ-015/018; single-cycle pin pulses of >=1 phi1 period are accepted for NMI.

Structure
REQ-030 Shared package holds reset FSM state constants (RS_IDLE=0, RS_LOW=1, RS_PEND=2), status bit index I_BIT=2, and NMI_CNT_MAX=15.
REQ-031 One sub-module, intc_sync, instantiated three times: 2-flop synchronizer plus optional filter under INTC_GLITCH_FILTER_EN.

Verification
REQ-032 NMI_n low for 1 cycle at cycle 10 -> nmi=1 at cycle 13; nmiHandled at 20 -> nmi=0 at 21; nmiCount=0.
REQ-033 Three NMI_n falling edges 4 cycles apart, no ack -> nmi stays 1, nmiCount=2.
REQ-034 IRQ_n low, statusReg=8'h04 -> irq=0; statusReg=8'h00 -> irq=1 one cycle later; IRQ_n high -> irq=0 after 3 cycles.
REQ-035 RES_n low 1 synchronized cycle -> rst stays 0; RES_n low 4 cycles then high -> rst=1 until rstHandled, nmi forced 0 meanwhile.
REQ-036 nmiHandled and new NMI edge in the same cycle -> nmi remains 1; rstAll mid-RS_PEND -> rst=0, nmiCount=0 next cycle.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants for the interrupt controller: reset-FSM encoding,
// status-register bit position and counter limits.
package interrupt_ctrl_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_LOW  = 2'd1,
    RS_PEND = 2'd2
  } rs_state_t;

  localparam int         I_BIT       = 2;
  localparam logic [3:0] NMI_CNT_MAX = 4'd15;
  localparam logic [2:0] RS_CNT_MAX  = 3'd7;
  localparam logic [2:0] RS_CNT_MIN  = 3'd2;

endpackage

// File: rtl/intc_sync.sv
// Two-flop pin synchronizer with a sample-validity flag; optional 2-cycle
// stability filter when INTC_GLITCH_FILTER_EN is defined.
module intc_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_valid
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_vld;

  // r_vld marks when r_sync holds a real pin sample rather than the reset value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_vld  <= 2'b00;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_vld  <= {r_vld[0], 1'b1};
    end
  end

`ifdef INTC_GLITCH_FILTER_EN
  logic       r_last;
  logic       r_filt;
  logic [1:0] r_fvld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
      r_filt <= 1'b1;
      r_fvld <= 2'b00;
    end else begin
      r_last <= r_sync;
      if (r_sync == r_last) r_filt <= r_sync;
      r_fvld <= {r_fvld[0], r_vld[1]};
    end
  end

  assign o_sync  = r_filt;
  assign o_valid = r_fvld[1];
`else
  assign o_sync  = r_sync;
  assign o_valid = r_vld[1];
`endif

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: NMI edge latch with overflow count, level IRQ masked
// by the I flag, and a debounced reset-request FSM. Filter: INTC_GLITCH_FILTER_EN.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
(
  input  logic       phi1,
  input  logic       rstAll,
  input  logic       NMI_n,
  input  logic       IRQ_n,
  input  logic       RES_n,
  input  logic [7:0] statusReg,
  input  logic       nmiHandled,
  input  logic       irqHandled,
  input  logic       rstHandled,
  output logic       nmi,
  output logic       irq,
  output logic       rst,
  output logic [3:0] nmiCount
);

  logic w_snmi, w_nmi_vld;
  logic w_sirq, w_irq_vld;
  logic w_sres, w_res_vld;
  logic w_nmi_fall, w_res_low, w_rs_idle;
  logic w_unused_ack;
  logic w_unused_status;

  rs_state_t r_rs_state;
  logic [2:0] r_rs_cnt;
  logic       r_nmi_prev;
  logic       r_nmi_prev_vld;
  logic       r_nmi_pend;
  logic [3:0] r_nmi_cnt;
  logic       r_irq;

  intc_sync u_sync_nmi (.i_clk(phi1), .i_rst(rstAll), .i_pin(NMI_n), .o_sync(w_snmi), .o_valid(w_nmi_vld));
  intc_sync u_sync_irq (.i_clk(phi1), .i_rst(rstAll), .i_pin(IRQ_n), .o_sync(w_sirq), .o_valid(w_irq_vld));
  intc_sync u_sync_res (.i_clk(phi1), .i_rst(rstAll), .i_pin(RES_n), .o_sync(w_sres), .o_valid(w_res_vld));

  // A pin held low through rstAll never yields an edge: both samples must be real
  assign w_nmi_fall = r_nmi_prev_vld & r_nmi_prev & ~w_snmi;
  assign w_res_low  = w_res_vld & ~w_sres;
  assign w_rs_idle  = (r_rs_state == RS_IDLE);

  assign w_unused_ack    = irqHandled;
  assign w_unused_status = ^{statusReg[7:I_BIT+1], statusReg[I_BIT-1:0]};

  always_ff @(posedge phi1) begin
    if (rstAll) begin
      r_nmi_prev     <= 1'b1;
      r_nmi_prev_vld <= 1'b0;
      r_nmi_pend     <= 1'b0;
      r_nmi_cnt      <= 4'd0;
      r_irq          <= 1'b0;
    end else begin
      r_nmi_prev     <= w_snmi;
      r_nmi_prev_vld <= w_nmi_vld;
      if (w_nmi_fall)      r_nmi_pend <= 1'b1;
      else if (nmiHandled) r_nmi_pend <= 1'b0;
      if (w_nmi_fall && r_nmi_pend && !nmiHandled && r_nmi_cnt != NMI_CNT_MAX)
        r_nmi_cnt <= r_nmi_cnt + 4'd1;
      r_irq <= w_irq_vld & ~w_sirq & ~statusReg[I_BIT];
    end
  end

  always_ff @(posedge phi1) begin
    if (rstAll) begin
      r_rs_state <= RS_IDLE;
      r_rs_cnt   <= 3'd0;
    end else begin
      case (r_rs_state)
        RS_IDLE: begin
          if (w_res_low) begin
            r_rs_state <= RS_LOW;
            r_rs_cnt   <= 3'd0;
          end
        end
        RS_LOW: begin
          if (w_res_low) begin
            if (r_rs_cnt != RS_CNT_MAX) r_rs_cnt <= r_rs_cnt + 3'd1;
          end else if (r_rs_cnt >= RS_CNT_MIN) begin
            r_rs_state <= RS_PEND;
          end else begin
            r_rs_state <= RS_IDLE;
          end
        end
        RS_PEND: begin
          if (rstHandled) begin
            r_rs_state <= RS_IDLE;
          end else if (w_res_low) begin
            r_rs_state <= RS_LOW;
            r_rs_cnt   <= 3'd0;
          end
        end
        default: r_rs_state <= RS_IDLE;
      endcase
    end
  end

  assign nmi      = r_nmi_pend & w_rs_idle;
  assign irq      = r_irq & w_rs_idle;
  assign rst      = (r_rs_state == RS_PEND);
  assign nmiCount = r_nmi_cnt;

endmodule
